// File: rtl/seq_mag_cmp.sv
// Multi-cycle magnitude comparator: scans two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
// Build option SEQ_MAG_CMP_EARLY_EXIT_EN finishes on the first differing chunk instead of a fixed N-cycle scan.
//
// state | meaning
// IDLE  | waiting for start, flags hold last result
// RUN   | scanning chunks from idx=N-1 down to 0
module seq_mag_cmp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             grtr_out,
  output logic             eql_out
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_cfg
      $error("seq_mag_cmp: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               grtr_q, grtr_d;
  logic               eql_q, eql_d;
  logic               done_q, done_d;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
  logic               miss_q, miss_d;
  logic               miss_grtr_q, miss_grtr_d;
`endif

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic               chunk_ne;
  logic               chunk_gt;
  logic               last_chunk;

  assign a_chunk    = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk    = b_q[idx_q*CHUNK +: CHUNK];
  assign chunk_ne   = (a_chunk != b_chunk);
  assign chunk_gt   = (a_chunk > b_chunk);
  assign last_chunk = (idx_q == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    grtr_d  = grtr_q;
    eql_d   = eql_q;
    done_d  = 1'b0;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
    miss_d      = miss_q;
    miss_grtr_d = miss_grtr_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d     = signed_in ? (a_in ^ MSB_MASK) : a_in;
          b_d     = signed_in ? (b_in ^ MSB_MASK) : b_in;
          idx_d   = IDX_W'(N - 1);
          state_d = RUN;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
          miss_d      = 1'b0;
          miss_grtr_d = 1'b0;
`endif
        end
      end

      RUN: begin
`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
        if (chunk_ne) begin
          grtr_d  = chunk_gt;
          eql_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (last_chunk) begin
          grtr_d  = 1'b0;
          eql_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`else
        if (last_chunk) begin
          done_d  = 1'b1;
          state_d = IDLE;
          // The most significant differing chunk decides; later ones are ignored.
          if (miss_q) begin
            grtr_d = miss_grtr_q;
            eql_d  = 1'b0;
          end else if (chunk_ne) begin
            grtr_d = chunk_gt;
            eql_d  = 1'b0;
          end else begin
            grtr_d = 1'b0;
            eql_d  = 1'b1;
          end
        end else begin
          if (!miss_q && chunk_ne) begin
            miss_d      = 1'b1;
            miss_grtr_d = chunk_gt;
          end
          idx_d = idx_q - IDX_W'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      grtr_q  <= 1'b0;
      eql_q   <= 1'b0;
      done_q  <= 1'b0;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
      miss_q      <= 1'b0;
      miss_grtr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      grtr_q  <= grtr_d;
      eql_q   <= eql_d;
      done_q  <= done_d;
`ifndef SEQ_MAG_CMP_EARLY_EXIT_EN
      miss_q      <= miss_d;
      miss_grtr_q <= miss_grtr_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign grtr_out = grtr_q;
  assign eql_out  = eql_q;

endmodule
